// File: rtl/pls_tx_sequencer.sv
// pls_tx_sequencer
//   Converts a MAC byte stream into a sequence of one-hot PLS data requests:
//   preamble, SFD, frame data (LSB first), optional carrier extension,
//   error extension on abort/underrun, then inter-frame gap.
//   An internal phase bit divides clk by two. Only "update edges" (phase=1)
//   advance the request stream, so each request is held for two clk cycles.
//
// Ports
//   clk              in   system clock, rising edge
//   reset            in   synchronous, active-high
//   frm_valid        in   MAC byte available on frm_data
//   frm_data[7:0]    in   frame byte (destination address onward)
//   frm_last         in   frm_data is the final byte of the frame
//   frm_abort        in   level; abort current frame (SFD/DATA/EXTEND only)
//   frm_ready        out  registered; a byte is taken on the next update edge
//   pls_data_request out  one-hot {DATA_COMPLETE,EXTEND,EXTEND_ERROR,ONE,ZERO}
//   busy             out  high whenever not IDLE
//
// Configuration macro
//   PLS_CARRIER_EXT_EN  defined: short frames are padded with EXTEND up to
//                       SLOT_BITS; undefined: final data bit goes straight to IFG.
module pls_tx_sequencer #(
    parameter int SLOT_BITS = 512,
    parameter int ERR_BITS  = 8,
    parameter int IFG_BITS  = 96
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frm_valid,
    input  logic [7:0] frm_data,
    input  logic       frm_last,
    input  logic       frm_abort,
    output logic       frm_ready,
    output logic [4:0] pls_data_request,
    output logic       busy
);

    localparam logic [4:0] REQ_ZERO = 5'b00001;
    localparam logic [4:0] REQ_ONE  = 5'b00010;
    localparam logic [4:0] REQ_EERR = 5'b00100;
    localparam logic [4:0] REQ_EXT  = 5'b01000;
    localparam logic [4:0] REQ_DC   = 5'b10000;

    localparam logic [12:0] PRE_CNT  = 13'd56;
    localparam logic [12:0] SFD_CNT  = 13'd8;
    localparam logic [12:0] SLOT_CNT = 13'(SLOT_BITS);
    localparam logic [12:0] ERR_CNT  = 13'(ERR_BITS);
    localparam logic [12:0] IFG_CNT  = 13'(IFG_BITS);
    localparam logic [7:0]  SFD_BYTE = 8'hD5;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_DATA, S_EXTEND, S_ERROR, S_IFG
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_phase;
    logic [12:0] r_cnt, w_cnt_next;            // requests issued in PREAMBLE/SFD/ERROR/IFG
    logic [12:0] r_data_cnt, w_data_cnt_next;  // data bits issued this frame
    logic [12:0] r_ext_cnt, w_ext_cnt_next;    // EXTEND requests issued
    logic [7:0]  r_byte, w_byte_next;
    logic        r_last, w_last_next;
    logic [4:0]  r_req, w_req_next;
    logic        r_ready, w_ready_next;
    logic        w_capture_due;

    function automatic logic [4:0] bit_req(input logic b);
        return b ? REQ_ONE : REQ_ZERO;
    endfunction

    // Next update edge issues bit 0 of a new byte. Every byte boundary in
    // DATA falls on a multiple of 8 data bits, so the low 3 bits suffice.
    assign w_capture_due = (r_state == S_SFD  && r_cnt == SFD_CNT) ||
                           (r_state == S_DATA && r_data_cnt[2:0] == 3'd0 && !r_last);

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_data_cnt_next = r_data_cnt;
        w_ext_cnt_next  = r_ext_cnt;
        w_byte_next     = r_byte;
        w_last_next     = r_last;
        w_req_next      = r_req;
        w_ready_next    = 1'b0;

        if (!r_phase) begin
            // Non-update edge: raise ready for the cycle preceding a capture edge.
            w_ready_next = w_capture_due;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_req_next = REQ_DC;
                    if (frm_valid) begin
                        w_state_next    = S_PREAMBLE;
                        w_req_next      = REQ_ONE;
                        w_cnt_next      = 13'd1;
                        w_data_cnt_next = 13'd0;
                        w_ext_cnt_next  = 13'd0;
                    end
                end
                S_PREAMBLE: begin
                    if (r_cnt == PRE_CNT) begin
                        w_state_next = S_SFD;
                        w_req_next   = bit_req(SFD_BYTE[0]);
                        w_cnt_next   = 13'd1;
                    end else begin
                        // 0x55 LSB first: even request index -> ONE
                        w_req_next = bit_req(~r_cnt[0]);
                        w_cnt_next = r_cnt + 13'd1;
                    end
                end
                S_SFD, S_DATA: begin
                    if (frm_abort) begin
                        w_state_next = S_ERROR;
                        w_req_next   = REQ_EERR;
                        w_cnt_next   = 13'd1;
                    end else if (w_capture_due) begin
                        if (!frm_valid) begin
                            w_state_next = S_ERROR;
                            w_req_next   = REQ_EERR;
                            w_cnt_next   = 13'd1;
                        end else begin
                            w_state_next    = S_DATA;
                            w_byte_next     = frm_data;
                            w_last_next     = frm_last;
                            w_req_next      = bit_req(frm_data[0]);
                            w_data_cnt_next = r_data_cnt + 13'd1;
                        end
                    end else if (r_state == S_SFD) begin
                        w_req_next = bit_req(SFD_BYTE[r_cnt[2:0]]);
                        w_cnt_next = r_cnt + 13'd1;
                    end else if (r_data_cnt[2:0] == 3'd0) begin
                        // Final byte fully issued.
`ifdef PLS_CARRIER_EXT_EN
                        if (r_data_cnt < SLOT_CNT) begin
                            w_state_next   = S_EXTEND;
                            w_req_next     = REQ_EXT;
                            w_ext_cnt_next = 13'd1;
                        end else begin
                            w_state_next = S_IFG;
                            w_req_next   = REQ_DC;
                            w_cnt_next   = 13'd1;
                        end
`else
                        w_state_next = S_IFG;
                        w_req_next   = REQ_DC;
                        w_cnt_next   = 13'd1;
`endif
                    end else begin
                        w_req_next      = bit_req(r_byte[r_data_cnt[2:0]]);
                        w_data_cnt_next = r_data_cnt + 13'd1;
                    end
                end
                S_EXTEND: begin
                    if (frm_abort) begin
                        w_state_next = S_ERROR;
                        w_req_next   = REQ_EERR;
                        w_cnt_next   = 13'd1;
                    end else if (r_data_cnt + r_ext_cnt == SLOT_CNT) begin
                        w_state_next = S_IFG;
                        w_req_next   = REQ_DC;
                        w_cnt_next   = 13'd1;
                    end else begin
                        w_req_next     = REQ_EXT;
                        w_ext_cnt_next = r_ext_cnt + 13'd1;
                    end
                end
                S_ERROR: begin
                    if (r_cnt == ERR_CNT) begin
                        w_state_next = S_IFG;
                        w_req_next   = REQ_DC;
                        w_cnt_next   = 13'd1;
                    end else begin
                        w_req_next = REQ_EERR;
                        w_cnt_next = r_cnt + 13'd1;
                    end
                end
                S_IFG: begin
                    w_req_next = REQ_DC;
                    if (r_cnt == IFG_CNT) begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = 13'd0;
                    end else begin
                        w_cnt_next = r_cnt + 13'd1;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_req_next   = REQ_DC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_phase    <= 1'b0;
            r_cnt      <= 13'd0;
            r_data_cnt <= 13'd0;
            r_ext_cnt  <= 13'd0;
            r_byte     <= 8'd0;
            r_last     <= 1'b0;
            r_req      <= REQ_DC;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_phase    <= ~r_phase;
            r_cnt      <= w_cnt_next;
            r_data_cnt <= w_data_cnt_next;
            r_ext_cnt  <= w_ext_cnt_next;
            r_byte     <= w_byte_next;
            r_last     <= w_last_next;
            r_req      <= w_req_next;
            r_ready    <= w_ready_next;
        end
    end

    assign frm_ready        = r_ready;
    assign pls_data_request = r_req;
    assign busy             = (r_state != S_IDLE);

endmodule

// File: doc/pls_tx_sequencer.md
PLS_TX_SEQUENCER -- requirements
Module: pls_tx_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  reset, synchronous, active-high; clock clk.
REQ-003 frm_valid  input  1  MAC byte available on frm_data.
REQ-004 frm_data  input  8  frame byte (destination address onward, no preamble/SFD).
REQ-005 frm_last  input  1  qualifies frm_data as final byte of frame.
REQ-006 frm_abort  input  1  MAC requests frame abort; level, sampled at update edges.
REQ-007 frm_ready  output  1  registered; byte transfer occurs on the next update edge when frm_valid=1.
REQ-008 pls_data_request  output  5  one-hot: 00001 ZERO, 00010 ONE, 00100 EXTEND_ERROR, 01000 EXTEND, 10000 DATA_COMPLETE.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 Parameters: SLOT_BITS default 512, ERR_BITS default 8, IFG_BITS default 96; all counters 13 bits.

Function
REQ-011 Internal phase bit toggles every clk; "update edge" = clk edge with phase=1; pls_data_request changes only at update edges, so each value is held exactly 2 clk cycles (one PLS request period at gtx_clk = clk/2).
REQ-012 States: IDLE, PREAMBLE, SFD, DATA, EXTEND, ERROR, IFG.
REQ-013 IDLE: output DATA_COMPLETE; on update edge with frm_valid=1 go to PREAMBLE, issuing first preamble bit at that edge.
REQ-014 PREAMBLE: 56 requests alternating ONE, ZERO, starting ONE (0x55 LSB first x7).
REQ-015 SFD: 8 requests of 0xD5 LSB first: ONE ZERO ONE ZERO ONE ZERO ONE ONE.
REQ-016 DATA: each byte issued as 8 requests, LSB first, bit 1 -> ONE, bit 0 -> ZERO; data bit counter increments per request.
REQ-017 frm_ready is high exactly for the single clk cycle before the update edge that issues bit 0 of a byte (first byte: edge after last SFD bit); byte and frm_last captured on that edge.
REQ-018 After bit 7 of a byte captured with frm_last=1: go to EXTEND if data bit count < SLOT_BITS, else IFG.
REQ-019 EXTEND: issue EXTEND until data bit count + extend count = SLOT_BITS, then IFG.
REQ-020 Underrun: frm_valid=0 at a byte-capture edge in DATA -> ERROR.
REQ-021 frm_abort=1 at any update edge in SFD, DATA or EXTEND -> ERROR at that edge; abort ignored in IDLE, PREAMBLE, IFG.
REQ-022 ERROR: issue EXTEND_ERROR for ERR_BITS requests, then IFG; frm_ready held low; no further bytes consumed.
REQ-023 IFG: issue DATA_COMPLETE for IFG_BITS requests, frm_valid ignored, then IDLE.
REQ-024 Abort and frm_last on the same edge: abort wins.
REQ-025 pls_data_request is always exactly one-hot; never 00000.

Reset
REQ-026 On reset: state IDLE, phase 0, all counters 0, frm_ready 0, busy 0, pls_data_request 10000.
REQ-027 Reset mid-frame takes effect on that clk edge; no trailing EXTEND_ERROR or IFG is issued.

Configuration
REQ-028 Macro PLS_CARRIER_EXT_EN: defined -> EXTEND state and REQ-018/019 slot padding present; undefined -> after final data bit go directly to IFG, EXTEND never issued, SLOT_BITS unused.

Verification
REQ-029 Single byte 0xA5 with frm_last, macro defined -> 56 alternating ONE/ZERO, SFD pattern, ONE ZERO ONE ZERO ZERO ONE ZERO ONE, 504 EXTEND, 96 DATA_COMPLETE, busy low; each value held 2 clk.
REQ-030 Same stimulus, macro undefined -> 8 data requests followed directly by 96 DATA_COMPLETE; zero EXTEND.
REQ-031 64-byte frame, frm_valid continuously high -> 64 frm_ready pulses, 512 data requests, no EXTEND.
REQ-032 frm_abort asserted during byte 3 -> EXTEND_ERROR from that edge for 8 requests, then 96 DATA_COMPLETE; no byte 4 consumed.
REQ-033 frm_valid dropped before byte 2 capture -> 8 EXTEND_ERROR, then IFG.
REQ-034 reset asserted during DATA -> next clk pls_data_request=10000, frm_ready=0, busy=0; new frame starts with full preamble.
